// File: rtl/seg7_scan_driver.sv
// Three-digit multiplexed 7-segment driver with frame-synchronous load.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] bcd_in,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    D_ONES = 2'd0,
    D_TENS = 2'd1,
    D_HUND = 2'd2
  } digit_e;

  localparam logic [CNT_W-1:0] TOP = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  digit_e           idx_q, idx_d;
  logic [11:0]      disp_q, pval_q;
  logic             pend_q;
  logic             tick, bnd;
  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       seg_d;
  logic [2:0]       an_d;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'd0:    c = 7'b0000001;
      4'd1:    c = 7'b1001111;
      4'd2:    c = 7'b0010010;
      4'd3:    c = 7'b0000110;
      4'd4:    c = 7'b1001100;
      4'd5:    c = 7'b0100100;
      4'd6:    c = 7'b0100000;
      4'd7:    c = 7'b0001111;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0000100;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  assign tick = (cnt_q == TOP);
  assign bnd  = tick && (idx_q == D_HUND);

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      unique case (idx_q)
        D_ONES:  idx_d = D_TENS;
        D_TENS:  idx_d = D_HUND;
        default: idx_d = D_ONES;
      endcase
    end
  end

  always_comb begin
    nib   = disp_q[3:0];
    blank = 1'b0;
    an_d  = 3'b110;
    unique case (idx_q)
      D_TENS: begin
        nib  = disp_q[7:4];
        an_d = 3'b101;
      end
      D_HUND: begin
        nib  = disp_q[11:8];
        an_d = 3'b011;
      end
      default: begin
        nib  = disp_q[3:0];
        an_d = 3'b110;
      end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // Ones digit is never blanked so zero still reads "  0".
    if (idx_q == D_HUND)
      blank = (disp_q[11:8] == 4'd0);
    else if (idx_q == D_TENS)
      blank = (disp_q[11:4] == 8'd0);
`endif
    seg_d = blank ? 7'b1111111 : dec(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= D_ONES;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      idx_q <= idx_d;
    end
  end

  // A load coinciding with the boundary bypasses the pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= 12'h000;
      pval_q <= 12'h000;
      pend_q <= 1'b0;
    end else if (bnd) begin
      if (load) begin
        disp_q <= bcd_in;
        pend_q <= 1'b0;
      end else if (pend_q) begin
        disp_q <= pval_q;
        pend_q <= 1'b0;
      end
    end else if (load) begin
      pval_q <= bcd_in;
      pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'b1111111;
      an         <= 3'b111;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= bnd;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed steps plus random loads
// against a frame-position reference model (REFRESH_DIV=4).
module tb_seg7_scan_driver;

  localparam int RD = 4;
  localparam int FR = 3 * RD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [11:0] bcd_in;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  int          k;
  logic [11:0] m_disp, m_pval;
  logic        m_pend;

  logic [6:0] ctab [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  seg7_scan_driver #(
    .REFRESH_DIV(RD),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .bcd_in    (bcd_in),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int dig,
                                         input logic [11:0] v);
    int n;
    n = int'((v >> (4 * dig)) & 12'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (dig == 2 && v[11:8] == 0) return 7'b1111111;
    if (dig == 1 && v[11:4] == 0) return 7'b1111111;
`endif
    if (n > 9) return 7'b1111111;
    return ctab[n];
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs,
                     input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s k=%0d: got %b want %b", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    m_disp = 12'h000;
    m_pval = 12'h000;
    m_pend = 1'b0;
  endtask

  // One clock: edge number k+1 shows digit (k/RD)%3 of the pre-edge display.
  task automatic cyc(input logic ld, input logic [11:0] v);
    int         dig;
    logic       b;
    logic [6:0] es;
    logic [2:0] ea;
    load   = ld;
    bcd_in = v;
    dig = (k / RD) % 3;
    ea  = ~(3'b001 << dig);
    es  = exp_seg(dig, m_disp);
    b   = ((k + 1) % FR) == 0;
    if (b) begin
      if (ld) begin
        m_disp = v;
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_disp = m_pval;
        m_pend = 1'b0;
      end
    end else if (ld) begin
      m_pval = v;
      m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    k++;
    chk("an", {4'b0, an}, {4'b0, ea});
    chk("seg", seg, es);
    chk("frame_done", {6'b0, frame_done}, {6'b0, b});
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'h000);
  endtask

  task automatic to_boundary_minus1();
    while ((k % FR) != FR - 1) cyc(1'b0, 12'h000);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"}, seg, 7'b1111111);
    chk({tag, "_an"}, {4'b0, an}, 7'b0000111);
    chk({tag, "_fd"}, {6'b0, frame_done}, 7'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    bcd_in = 12'h000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // walk through two frames of zeros
    idle(2 * FR);

    // 255 loaded mid-frame
    idle(5);
    cyc(1'b1, 12'h255);
    idle(2 * FR + 3);

    // last load in a frame wins
    idle(2);
    cyc(1'b1, 12'h123);
    idle(1);
    cyc(1'b1, 12'h789);
    idle(2 * FR);

    // load on the boundary cycle
    to_boundary_minus1();
    cyc(1'b1, 12'h040);
    idle(FR);

    // invalid nibbles blank
    cyc(1'b1, 12'h0AF);
    idle(2 * FR);

    // random loads
    for (int i = 0; i < 600; i++) begin
      logic [11:0] v;
      logic        ld;
      v  = 12'($urandom);
      if ($urandom_range(3) != 0) begin
        v[3:0]  = 4'($urandom_range(9));
        v[7:4]  = 4'($urandom_range(9));
        v[11:8] = 4'($urandom_range(1) == 0 ? 0 : $urandom_range(9));
      end
      ld = ($urandom_range(7) == 0);
      cyc(ld, v);
    end

    // reset mid-frame discards everything
    idle(3);
    cyc(1'b1, 12'h999);
    idle(FR + 2);
    cyc(1'b1, 12'h999);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    chk_reset_vals("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(2 * FR + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
